// File: rtl/decode_skid_reg_pkg.sv
// Shared IF/ID definitions: MIPS opcode constants, field bit positions and
// occupancy state encoding for the decode skid register.
package decode_skid_reg_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  // Logical immediates and LUI take their imm16 unsigned.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/decode_skid_reg_slicer.sv
// instr_field_slicer: combinational split of a MIPS32 word into its fields,
// plus the zero/sign-extend select for imm16. Shared with later stages.
module instr_field_slicer
  import decode_skid_reg_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o,
  output logic        zext_sel_o
);

  assign opcode_o   = instr_i[OPC_MSB:OPC_LSB];
  assign rs_o       = instr_i[RS_MSB:RS_LSB];
  assign rt_o       = instr_i[RT_MSB:RT_LSB];
  assign rd_o       = instr_i[RD_MSB:RD_LSB];
  assign shamt_o    = instr_i[SH_MSB:SH_LSB];
  assign funct_o    = instr_i[FN_MSB:FN_LSB];
  assign imm16_o    = instr_i[IMM_MSB:IMM_LSB];
  assign zext_sel_o = is_zext_op(instr_i[OPC_MSB:OPC_LSB]);

endmodule

// File: rtl/decode_skid_reg.sv
// IF/ID stage register with a 2-entry skid buffer and MIPS field decode.
// Optional DECODE_STALL_CNT_EN adds a free-running stall_cnt output.
module decode_skid_reg
  import decode_skid_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic              zext_sel,
  output logic [PC_W-1:0]   out_pc4
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  occ_state_e        state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] head_instr_q, head_instr_d;
  logic [PC_W-1:0]   head_pc4_q, head_pc4_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]   skid_pc4_q, skid_pc4_d;
  logic              acc, pop;
  logic [DATA_W-1:0] head_vis;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc4_d   = head_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          head_instr_d = in_instr;
          head_pc4_d   = in_pc4;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && !pop) begin
          skid_instr_d = in_instr;
          skid_pc4_d   = in_pc4;
          state_d      = ST_TWO;
        end else if (acc && pop) begin
          head_instr_d = in_instr;
          head_pc4_d   = in_pc4;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_instr_d = skid_instr_q;
          head_pc4_d   = skid_pc4_q;
          state_d      = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      head_instr_q <= '0;
      head_pc4_q   <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d != ST_TWO);
      head_instr_q <= head_instr_d;
      head_pc4_q   <= head_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Gating the head before slicing forces every decode output to 0 when idle.
  assign head_vis = out_valid ? head_instr_q : '0;
  assign out_pc4  = out_valid ? head_pc4_q : '0;

  instr_field_slicer u_slicer (
    .instr_i    (head_vis),
    .opcode_o   (opcode),
    .rs_o       (rs),
    .rt_o       (rt),
    .rd_o       (rd),
    .shamt_o    (shamt),
    .funct_o    (funct),
    .imm16_o    (imm16),
    .zext_sel_o (zext_sel)
  );

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_skid_reg.sv
// Scoreboard bench for decode_skid_reg: directed words with hand-decoded
// fields; a negedge monitor pops and compares on every handshake.
module tb_decode_skid_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic        zx;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc4, out_pc4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic        zext_sel;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   p0;
  logic mon_en = 1'b0;
  vec_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  decode_skid_reg #(.DATA_W(32), .PC_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc4    (in_pc4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm16     (imm16),
    .zext_sel  (zext_sel),
    .out_pc4   (out_pc4)
`ifdef DECODE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!out_valid) begin
        check("idle_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
        check("idle_imm", {15'b0, zext_sel, imm16}, 32'h0);
        check("idle_pc4", out_pc4, 32'h0);
      end else if (out_ready && !flush && !reset) begin
        pops++;
        if (sb.size() == 0) begin
          check("unexpected_pop", opcode, 32'hFFFF_FFFF);
        end else begin
          vec_t e;
          e = sb.pop_front();
          check("opcode", {26'b0, opcode}, {26'b0, e.op});
          check("rs", {27'b0, rs}, {27'b0, e.rs});
          check("rt", {27'b0, rt}, {27'b0, e.rt});
          check("rd", {27'b0, rd}, {27'b0, e.rd});
          check("shamt", {27'b0, shamt}, {27'b0, e.sh});
          check("funct", {26'b0, funct}, {26'b0, e.fn});
          check("imm16", {16'b0, imm16}, {16'b0, e.imm});
          check("zext_sel", {31'b0, zext_sel}, {31'b0, e.zx});
          check("out_pc4", out_pc4, e.pc4);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input vec_t v);
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc4   = v.pc4;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                instr         pc4           op     rs     rt     rd     sh     fn     imm       zx
    vecs[0] = '{32'h3401ABCD, 32'h00001004, 6'h0D, 5'h00, 5'h01, 5'h15, 5'h0F, 6'h0D, 16'hABCD, 1'b1};
    vecs[1] = '{32'h2001FFFF, 32'h00001008, 6'h08, 5'h00, 5'h01, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 1'b0};
    vecs[2] = '{32'h00221820, 32'h0000100C, 6'h00, 5'h01, 5'h02, 5'h03, 5'h00, 6'h20, 16'h1820, 1'b0};
    vecs[3] = '{32'h3C0A1234, 32'h00001010, 6'h0F, 5'h00, 5'h0A, 5'h02, 5'h08, 6'h34, 16'h1234, 1'b1};
    vecs[4] = '{32'h30E500FF, 32'h00001014, 6'h0C, 5'h07, 5'h05, 5'h00, 5'h03, 6'h3F, 16'h00FF, 1'b1};
    vecs[5] = '{32'h38000001, 32'h00001018, 6'h0E, 5'h00, 5'h00, 5'h00, 5'h00, 6'h01, 16'h0001, 1'b1};
    vecs[6] = '{32'h8C000004, 32'h0000101C, 6'h23, 5'h00, 5'h00, 5'h00, 5'h00, 6'h04, 16'h0004, 1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc4 = '0;
    tick(1);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", {31'b0, in_ready}, 32'h1);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      tick(1);
    end
    reset = 1'b0;
    tick(1);

    // Streaming with decode always ready: each word decoded one cycle later.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(vecs[i]);
    tick(3);
    check("stream_drain", sb.size(), 32'd0);
    check("stream_pops", pops, 32'd7);

    // Fill both entries, then release: A and B on consecutive cycles.
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    check("full_in_ready", {31'b0, in_ready}, 32'h0);
    check("full_out_valid", {31'b0, out_valid}, 32'h1);
    tick(2);
    check("hold_in_ready", {31'b0, in_ready}, 32'h0);
    p0 = pops;
    out_ready = 1'b1;
    tick(1);
    check("release_pop_a", pops, p0 + 1);
    check("release_valid_b", {31'b0, out_valid}, 32'h1);
    tick(1);
    check("release_pop_b", pops, p0 + 2);
    check("release_empty", {31'b0, out_valid}, 32'h0);
    check("release_ready", {31'b0, in_ready}, 32'h1);
    check("release_sb", sb.size(), 32'd0);

    // Flush while full with a word on offer.
    out_ready = 1'b0;
    send(vecs[2]);
    send(vecs[3]);
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[4].instr; in_pc4 = vecs[4].pc4;
    tick(1);
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush2_out_valid", {31'b0, out_valid}, 32'h0);
    check("flush2_in_ready", {31'b0, in_ready}, 32'h1);

    // Flush in ONE while a word is actually accepted: it must be dropped.
    send(vecs[5]);
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[6].instr; in_pc4 = vecs[6].pc4;
    tick(1);
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush1_out_valid", {31'b0, out_valid}, 32'h0);
    p0 = pops;
    out_ready = 1'b1;
    send(vecs[4]);
    tick(2);
    check("post_flush_pops", pops, p0 + 1);
    check("post_flush_sb", sb.size(), 32'd0);

    // Reset mid-stall discards both entries.
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb.delete();
    check("rst_stall_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_stall_in_ready", {31'b0, in_ready}, 32'h1);

`ifdef DECODE_STALL_CNT_EN
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b0;
    send(vecs[5]);
    check("stall_cnt_start", stall_cnt, 32'd0);
    tick(5);
    check("stall_cnt_5", stall_cnt, 32'd5);
    flush = 1'b1; out_ready = 1'b1;
    tick(1);
    flush = 1'b0;
    sb.delete();
    check("stall_cnt_flush", stall_cnt, 32'd5);
    check("stall_flush_valid", {31'b0, out_valid}, 32'h0);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
